// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter.
// Provides the word width, the default instruction-memory address width,
// the NOP returned on faulting fetches, and the lock-state and owner-tag enums.
package imem_arbiter_pkg;

    localparam int unsigned WORD_BITS               = 32;
    localparam int unsigned INSTRUCTION_MEMORY_BITS = 12;

    // addi x0, x0, 0
    localparam logic [WORD_BITS-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        LOCK_UNLOCKED,
        LOCK_DRAIN,
        LOCK_LOCKED
    } lock_state_e;

    // Who receives the response in the cycle after a grant.
    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_FETCH,
        OWNER_FETCH_FAULT,
        OWNER_LOAD
    } owner_e;

endpackage

// File: rtl/imem_rr_arbiter.sv
// Two-way round-robin choice between fetch and loader.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   req_fetch, req_load   - eligible requests this cycle
//   gnt_fetch, gnt_load   - one-hot (or zero) grant, combinational
// On a tie the requester not granted most recently wins; after reset the
// loader counts as the last winner so fetch wins the first tie.
module imem_rr_arbiter (
    input  logic clock,
    input  logic reset,
    input  logic req_fetch,
    input  logic req_load,
    output logic gnt_fetch,
    output logic gnt_load
);

    logic last_load;

    always_comb begin
        gnt_fetch = req_fetch && (!req_load || last_load);
        gnt_load  = req_load && !gnt_fetch;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_load <= 1'b1;
        end else if (gnt_fetch) begin
            last_load <= 1'b0;
        end else if (gnt_load) begin
            last_load <= 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter between the fetch stage and the program loader.
// Ports:
//   clock, reset                           - clock, synchronous active-high reset
//   fetch_req/fetch_addr                   - fetch read request (byte address)
//   fetch_gnt/fetch_rvalid/fetch_rdata/fetch_fault - fetch grant and response
//   load_req/load_we/load_addr/load_wdata  - loader request
//   load_gnt/load_rvalid/load_rdata        - loader grant and read response
//   load_lock/lock_active                  - loader exclusive-ownership handshake
//   mem_en/mem_we/mem_addr/mem_wdata       - memory command (word address)
//   mem_rdata                              - memory read data, one cycle after mem_en
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS = INSTRUCTION_MEMORY_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_req,
    input  logic [WORD_BITS-1:0]   fetch_addr,
    output logic                   fetch_gnt,
    output logic                   fetch_rvalid,
    output logic [WORD_BITS-1:0]   fetch_rdata,
    output logic                   fetch_fault,
    input  logic                   load_req,
    input  logic                   load_we,
    input  logic [WORD_BITS-1:0]   load_addr,
    input  logic [WORD_BITS-1:0]   load_wdata,
    output logic                   load_gnt,
    output logic                   load_rvalid,
    output logic [WORD_BITS-1:0]   load_rdata,
    input  logic                   load_lock,
    output logic                   lock_active,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_BITS-3:0]   mem_addr,
    output logic [WORD_BITS-1:0]   mem_wdata,
    input  logic [WORD_BITS-1:0]   mem_rdata
);

    lock_state_e          state_q, state_next;
    owner_e               owner_q, owner_next;
    logic [WORD_BITS-1:0] fetch_rdata_q, load_rdata_q;
    logic                 fetch_bad_addr;
    logic                 rr_fetch, rr_load;

    // Loader address low bits and out-of-range bits are deliberately dropped.
    logic unused_load_addr_bits;
    assign unused_load_addr_bits = ^{load_addr[1:0], load_addr[WORD_BITS-1:ADDR_BITS]};

    assign fetch_bad_addr = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> ADDR_BITS) != '0);

    // Reset gates requests so no grant or memory command escapes during reset.
    imem_rr_arbiter u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_fetch (fetch_req && !reset && (state_q == LOCK_UNLOCKED)),
        .req_load  (load_req && !reset),
        .gnt_fetch (rr_fetch),
        .gnt_load  (rr_load)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= LOCK_UNLOCKED;
            owner_q       <= OWNER_NONE;
            fetch_rdata_q <= '0;
            load_rdata_q  <= '0;
        end else begin
            state_q <= state_next;
            owner_q <= owner_next;
            if (fetch_rvalid) begin
                fetch_rdata_q <= fetch_rdata;
            end
            if (load_rvalid) begin
                load_rdata_q <= load_rdata;
            end
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            LOCK_UNLOCKED: if (load_lock)  state_next = LOCK_DRAIN;
            LOCK_DRAIN:    state_next = load_lock ? LOCK_LOCKED : LOCK_UNLOCKED;
            LOCK_LOCKED:   if (!load_lock) state_next = LOCK_UNLOCKED;
            default:       state_next = LOCK_UNLOCKED;
        endcase
    end

    always_comb begin
        fetch_gnt   = rr_fetch;
        load_gnt    = rr_load;
        lock_active = !reset && (state_q == LOCK_LOCKED);
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        owner_next  = OWNER_NONE;

        if (rr_fetch) begin
            if (fetch_bad_addr) begin
                owner_next = OWNER_FETCH_FAULT;
            end else begin
                mem_en     = 1'b1;
                mem_addr   = fetch_addr[ADDR_BITS-1:2];
                owner_next = OWNER_FETCH;
            end
        end else if (rr_load) begin
            mem_en     = 1'b1;
            mem_we     = load_we;
            mem_addr   = load_addr[ADDR_BITS-1:2];
            mem_wdata  = load_wdata;
            owner_next = load_we ? OWNER_NONE : OWNER_LOAD;
        end
    end

    // Response outputs: live memory data while valid, otherwise the held copy.
    always_comb begin
        fetch_rvalid = !reset && ((owner_q == OWNER_FETCH) || (owner_q == OWNER_FETCH_FAULT));
        fetch_fault  = !reset && (owner_q == OWNER_FETCH_FAULT);
        load_rvalid  = !reset && (owner_q == OWNER_LOAD);
        fetch_rdata  = fetch_rdata_q;
        load_rdata   = load_rdata_q;
        if (fetch_rvalid) begin
            fetch_rdata = fetch_fault ? NOP_INSTR : mem_rdata;
        end
        if (load_rvalid) begin
            load_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed table-driven bench for imem_arbiter with a behavioural word memory.
module tb_imem_arbiter;

    typedef struct packed {
        logic        reset;
        logic        fetch_req;
        logic [31:0] fetch_addr;
        logic        load_req;
        logic        load_we;
        logic [31:0] load_addr;
        logic [31:0] load_wdata;
        logic        load_lock;
    } in_t;

    typedef struct packed {
        logic        fetch_gnt;
        logic        load_gnt;
        logic        mem_en;
        logic        mem_we;
        logic [9:0]  mem_addr;
        logic [31:0] mem_wdata;
        logic        fetch_rvalid;
        logic        fetch_fault;
        logic [31:0] fetch_rdata;
        logic        load_rvalid;
        logic [31:0] load_rdata;
        logic        lock_active;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [31:0] D    = 32'hDEADBEEF;
    localparam logic [31:0] CAFE = 32'hCAFEF00D;
    localparam logic [31:0] W    = 32'h12345678;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt, fetch_rvalid, fetch_fault;
    logic [31:0] fetch_rdata;
    logic        load_req, load_we, load_lock;
    logic [31:0] load_addr, load_wdata;
    logic        load_gnt, load_rvalid, lock_active;
    logic [31:0] load_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic        mem_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    imem_arbiter #(.ADDR_BITS(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .fetch_fault  (fetch_fault),
        .load_req     (load_req),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_wdata   (load_wdata),
        .load_gnt     (load_gnt),
        .load_rvalid  (load_rvalid),
        .load_rdata   (load_rdata),
        .load_lock    (load_lock),
        .lock_active  (lock_active),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Synchronous memory: word i holds 0x1000_0000+i, word 4 holds DEADBEEF.
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= (i == 4) ? D : (32'h1000_0000 + 32'(i));
            end
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic in_t mk_in(int r, int fr, logic [31:0] fa, int lr, int lw,
                                  logic [31:0] la, logic [31:0] ld, int lk);
        in_t v;
        v.reset      = (r != 0);
        v.fetch_req  = (fr != 0);
        v.fetch_addr = fa;
        v.load_req   = (lr != 0);
        v.load_we    = (lw != 0);
        v.load_addr  = la;
        v.load_wdata = ld;
        v.load_lock  = (lk != 0);
        return v;
    endfunction

    function automatic out_t mk_out(int fg, int lg, int en, int we, logic [31:0] ma,
                                    logic [31:0] wd, int frv, int ff, logic [31:0] frd,
                                    int lrv, logic [31:0] lrd, int la);
        out_t v;
        v.fetch_gnt    = (fg != 0);
        v.load_gnt     = (lg != 0);
        v.mem_en       = (en != 0);
        v.mem_we       = (we != 0);
        v.mem_addr     = ma[9:0];
        v.mem_wdata    = wd;
        v.fetch_rvalid = (frv != 0);
        v.fetch_fault  = (ff != 0);
        v.fetch_rdata  = frd;
        v.load_rvalid  = (lrv != 0);
        v.load_rdata   = lrd;
        v.lock_active  = (la != 0);
        return v;
    endfunction

    task automatic apply(input in_t vi, input out_t vo, input string name);
        out_t got;
        @(negedge clock);
        reset      = vi.reset;
        fetch_req  = vi.fetch_req;
        fetch_addr = vi.fetch_addr;
        load_req   = vi.load_req;
        load_we    = vi.load_we;
        load_addr  = vi.load_addr;
        load_wdata = vi.load_wdata;
        load_lock  = vi.load_lock;
        #1;
        got = {fetch_gnt, load_gnt, mem_en, mem_we, mem_addr, mem_wdata,
               fetch_rvalid, fetch_fault, fetch_rdata, load_rvalid, load_rdata, lock_active};
        n_vec++;
        if (got !== vo) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, vo);
        end
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_req = 1'b0;
        load_we = 1'b0; load_addr = '0; load_wdata = '0; load_lock = 1'b0;
        repeat (2) @(posedge clock);

        // reset state, single fetch
        vecs.push_back('{mk_in(1,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0, 0,0,0, 0,0,0)});
        vecs.push_back('{mk_in(0,1,'h10,0,0,0,0,0),     mk_out(1,0,1,0,4,0, 0,0,0, 0,0,0)});
        vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0, 1,0,D, 0,0,0)});
        // reset clears last winner and held data (held value visible during reset)
        vecs.push_back('{mk_in(1,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0, 0,0,D, 0,0,0)});
        // both requesting: F, L, F, L
        vecs.push_back('{mk_in(0,1,'h08,1,0,'h0C,0,0),  mk_out(1,0,1,0,2,0,  0,0,0, 0,0,0)});
        vecs.push_back('{mk_in(0,1,'h14,1,0,'h18,0,0),  mk_out(0,1,1,0,6,0,  1,0,32'h10000002, 0,0,0)});
        vecs.push_back('{mk_in(0,1,'h1C,1,0,'h24,0,0),  mk_out(1,0,1,0,7,0,  0,0,32'h10000002, 1,32'h10000006,0)});
        vecs.push_back('{mk_in(0,1,'h28,1,0,'h2C,0,0),  mk_out(0,1,1,0,11,0, 1,0,32'h10000007, 0,32'h10000006,0)});
        vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0,  0,0,32'h10000007, 1,32'h1000000B,0)});
        // misaligned fetch faults
        vecs.push_back('{mk_in(0,1,'h06,0,0,0,0,0),     mk_out(1,0,0,0,0,0, 0,0,32'h10000007, 0,32'h1000000B,0)});
        vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0, 1,1,NOP, 0,32'h1000000B,0)});
        // out-of-range fetch faults
        vecs.push_back('{mk_in(0,1,'h1000,0,0,0,0,0),   mk_out(1,0,0,0,0,0, 0,0,NOP, 0,32'h1000000B,0)});
        vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0, 1,1,NOP, 0,32'h1000000B,0)});
        // loader write ignores low and high address bits, no rvalid
        vecs.push_back('{mk_in(0,0,0,1,1,'h1043,CAFE,0), mk_out(0,1,1,1,'h10,CAFE, 0,0,NOP, 0,32'h1000000B,0)});
        vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0, 0,0,NOP, 0,32'h1000000B,0)});
        vecs.push_back('{mk_in(0,1,'h40,0,0,0,0,0),     mk_out(1,0,1,0,'h10,0, 0,0,NOP, 0,32'h1000000B,0)});
        vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,0, 1,0,CAFE, 0,32'h1000000B,0)});

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));
        end

        // lock rises during a fetch grant; response still delivered
        apply(mk_in(0,1,'h10,0,0,0,0,1),       mk_out(1,0,1,0,4,0, 0,0,CAFE, 0,32'h1000000B,0), "lock_rise");
        apply(mk_in(0,1,'h10,0,0,0,0,1),       mk_out(0,0,0,0,0,0, 1,0,D, 0,32'h1000000B,0),    "lock_drain");
        apply(mk_in(0,1,'h10,1,1,'h20,W,1),    mk_out(0,1,1,1,8,W, 0,0,D, 0,32'h1000000B,1),    "lock_write");
        apply(mk_in(0,1,'h20,0,0,0,0,0),       mk_out(0,0,0,0,0,0, 0,0,D, 0,32'h1000000B,1),    "lock_release");
        apply(mk_in(0,1,'h20,0,0,0,0,0),       mk_out(1,0,1,0,8,0, 0,0,D, 0,32'h1000000B,0),    "unlocked_fetch");
        apply(mk_in(0,0,0,0,0,0,0,0),          mk_out(0,0,0,0,0,0, 1,0,W, 0,32'h1000000B,0),    "fetch_written");
        // lock dropped while in DRAIN returns straight to UNLOCKED
        apply(mk_in(0,0,0,0,0,0,0,1),          mk_out(0,0,0,0,0,0, 0,0,W, 0,32'h1000000B,0),    "drain_enter");
        apply(mk_in(0,1,0,0,0,0,0,0),          mk_out(0,0,0,0,0,0, 0,0,W, 0,32'h1000000B,0),    "drain_abort");
        apply(mk_in(0,1,0,0,0,0,0,0),          mk_out(1,0,1,0,0,0, 0,0,W, 0,32'h1000000B,0),    "after_abort");
        // reset the cycle after a loader read grant drops its response
        apply(mk_in(0,0,0,1,0,'h10,0,0),       mk_out(0,1,1,0,4,0, 1,0,32'h10000000, 0,32'h1000000B,0), "load_read");
        apply(mk_in(1,0,0,1,0,'h10,0,0),       mk_out(0,0,0,0,0,0, 0,0,32'h10000000, 0,32'h1000000B,0), "reset_mid");
        apply(mk_in(0,0,0,0,0,0,0,0),          mk_out(0,0,0,0,0,0, 0,0,0, 0,0,0),                       "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default `instruction_memory_bits`, the byte-address width of instruction memory.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port fetch_req, input, 1, fetch stage requests a read.
REQ-005 SHALL have port fetch_addr, input, word, fetch byte address.
REQ-006 SHALL have port fetch_gnt, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have ports fetch_rvalid / fetch_rdata / fetch_fault, output, 1 / word / 1, fetch response, its data and its fault flag.
REQ-008 SHALL have ports load_req / load_we / load_addr / load_wdata, input, 1 / 1 / word / word, program-loader request, write-enable, byte address and write data.
REQ-009 SHALL have ports load_gnt / load_rvalid / load_rdata, output, 1 / 1 / word, loader grant, read response and its data.
REQ-010 SHALL have port load_lock, input, 1, loader requests exclusive ownership; lock_active, output, 1, exclusive ownership held.
REQ-011 SHALL have ports mem_en / mem_we / mem_addr / mem_wdata, output, 1 / 1 / ADDR_BITS-2 / word, memory command with word address; mem_rdata, input, word, read data one cycle after mem_en.

Function
REQ-012 SHALL grant at most one requester per cycle; grants are combinational in the request cycle; mem_* is driven from the granted requester that cycle; mem_en=0 with no grant.
REQ-013 SHALL arbitrate round-robin when both request while unlocked: winner = requester not granted most recently; a lone requester always wins.
REQ-014 SHALL assert *_rvalid exactly one cycle after a granted read, with *_rdata = mem_rdata, routed by a registered owner tag; loader writes (load_we=1) produce no load_rvalid.
REQ-015 SHALL treat a fetch with fetch_addr[1:0]!=0 or any fetch_addr bit at or above ADDR_BITS set as a fault: fetch_gnt=1, mem_en=0, next cycle fetch_rvalid=1, fetch_fault=1, fetch_rdata=32'h00000013 (NOP).
REQ-016 SHALL ignore load_addr[1:0] and load_addr bits at or above ADDR_BITS (loader never faults).
REQ-017 SHALL run lock FSM UNLOCKED -> DRAIN when load_lock=1; DRAIN -> LOCKED after one cycle (outstanding response retires); LOCKED -> UNLOCKED when load_lock=0; DRAIN or LOCKED -> UNLOCKED immediately if load_lock drops.
REQ-018 SHALL give no fetch grants in DRAIN or LOCKED; loader requests are granted in every state; lock_active=1 only in LOCKED.
REQ-019 SHALL keep response delivery independent of lock state: a read granted in the cycle load_lock rises still returns its rvalid.
REQ-020 SHALL hold fetch_rdata/load_rdata stable at their last value when the matching rvalid is 0.

Reset
REQ-021 SHALL on reset force FSM to UNLOCKED, last-winner to loader (fetch wins first tie), owner tag to none, and all rvalid, fault, gnt, mem_en, mem_we, lock_active to 0; rdata registers to 0.
REQ-022 SHALL, on reset asserted mid-transaction, drop the pending response (no rvalid the following cycle).

Structure
REQ-023 SHALL place the lock-state enum, owner-tag enum and NOP constant in a shared package; word and memory-size macros come from definitions.vh.
REQ-024 SHALL implement the two-way round-robin choice as sub-module imem_rr_arbiter; remaining logic stays in imem_arbiter.

Verification
REQ-025 SHALL cover: fetch_req only, addr 0x10, mem holds 0xDEADBEEF at word 4 -> fetch_gnt same cycle, mem_addr=4, next cycle fetch_rvalid=1, fetch_rdata=0xDEADBEEF.
REQ-026 SHALL cover: both requesting 4 consecutive cycles after reset -> grants F,L,F,L; each rvalid on the correct port one cycle later.
REQ-027 SHALL cover: fetch addr 0x6 -> mem_en=0, next cycle fetch_rvalid=1, fetch_fault=1, fetch_rdata=0x00000013.
REQ-028 SHALL cover: load_lock rises while a fetch read is granted -> that fetch rvalid delivered, fetch_gnt=0 thereafter, lock_active=1 after DRAIN; loader write 0x12345678 to 0x20, lock released, fetch 0x20 returns 0x12345678.
REQ-029 SHALL cover: reset asserted the cycle after a loader read grant -> load_rvalid=0 next cycle, all outputs at reset values.
